// File: rtl/game_ctrl_if.sv
// Signal bundle between the game sequencer and the rest of the VGA runner top.
// The slave side is the sequencer; the master side drives the game inputs.
interface game_ctrl_if;
  logic       Vsynq;
  logic       button;
  logic       collision;
  logic       enemy_pass;
  logic       run;
  logic [3:0] enemy_speed;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [2:0] lives;
  logic       game_over;
  logic       led;
  logic       frame_tick;

  modport master (
    output Vsynq, button, collision, enemy_pass,
    input  run, enemy_speed, score_tens, score_ones, lives, game_over, led, frame_tick
  );

  modport slave (
    input  Vsynq, button, collision, enemy_pass,
    output run, enemy_speed, score_tens, score_ones, lives, game_over, led, frame_tick
  );
endinterface

// File: rtl/game_ctrl.sv
// Game sequencer: owns game state, lives, BCD score and enemy speed.
// Every game decision is paced by a frame tick derived from the Vsynq falling edge.
module game_ctrl #(
  parameter int LIVES      = 3,
  parameter int HIT_FRAMES = 60,
  parameter int SPEED_STEP = 5,
  parameter int BASE_SPEED = 1,
  parameter int MAX_SPEED  = 8
) (
  input logic        clk,
  input logic        reset,
  game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLAYING, HIT, GAME_OVER} state_t;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] HIT_LEN    = 8'(HIT_FRAMES);
  localparam logic [6:0] STEP_LEN   = 7'(SPEED_STEP);
  localparam logic [3:0] SPEED_INIT = 4'(BASE_SPEED);
  localparam logic [3:0] SPEED_MAX  = 4'(MAX_SPEED);

  state_t     state_q, state_d;
  logic       vs_q, vs_prev_q;
  logic       frame_tick_q, frame_tick_d;
  logic       btn_s1_q, btn_s2_q;
  logic       btn_frame_q, btn_frame_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] speed_q, speed_d;
  logic [2:0] lives_q, lives_d;
  logic       led_q, led_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [6:0] pts_q, pts_d;
  logic       press;
  logic [7:0] frame_cnt_inc;
  logic [6:0] pts_inc;

  always_comb begin
    frame_tick_d  = vs_prev_q & ~vs_q;
    press         = frame_tick_q & btn_s2_q & ~btn_frame_q;
    btn_frame_d   = frame_tick_q ? btn_s2_q : btn_frame_q;
    frame_cnt_inc = frame_cnt_q + 8'd1;
    pts_inc       = pts_q + 7'd1;

    state_d     = state_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    speed_d     = speed_q;
    lives_d     = lives_q;
    led_d       = led_q;
    frame_cnt_d = frame_cnt_q;
    pts_d       = pts_q;

    case (state_q)
      IDLE: begin
        if (press) state_d = PLAYING;
      end
      PLAYING: begin
        // Collision has priority over a simultaneous pass: no point is scored.
        if (bus.collision) begin
          state_d     = HIT;
          frame_cnt_d = 8'd0;
          led_d       = 1'b1;
          if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
        end else if (bus.enemy_pass && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
          if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
          if (pts_inc == STEP_LEN) begin
            pts_d = 7'd0;
            if (speed_q < SPEED_MAX) speed_d = speed_q + 4'd1;
          end else begin
            pts_d = pts_inc;
          end
        end
      end
      HIT: begin
        if (frame_tick_q) begin
          frame_cnt_d = frame_cnt_inc;
          if (frame_cnt_inc[2:0] == 3'd0) led_d = ~led_q;
          if (frame_cnt_inc == HIT_LEN) begin
            led_d   = 1'b0;
            state_d = (lives_q == 3'd0) ? GAME_OVER : PLAYING;
          end
        end
      end
      GAME_OVER: begin
        // Score and speed stay visible until the player restarts.
        if (press) begin
          state_d = IDLE;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
          lives_d = LIVES_INIT;
          speed_d = SPEED_INIT;
          pts_d   = 7'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      btn_s1_q     <= 1'b0;
      btn_s2_q     <= 1'b0;
      btn_frame_q  <= 1'b0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      speed_q      <= SPEED_INIT;
      lives_q      <= LIVES_INIT;
      led_q        <= 1'b0;
      frame_cnt_q  <= 8'd0;
      pts_q        <= 7'd0;
    end else begin
      state_q      <= state_d;
      vs_q         <= bus.Vsynq;
      vs_prev_q    <= vs_q;
      frame_tick_q <= frame_tick_d;
      btn_s1_q     <= bus.button;
      btn_s2_q     <= btn_s1_q;
      btn_frame_q  <= btn_frame_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      speed_q      <= speed_d;
      lives_q      <= lives_d;
      led_q        <= led_d;
      frame_cnt_q  <= frame_cnt_d;
      pts_q        <= pts_d;
    end
  end

  assign bus.run         = (state_q == PLAYING);
  assign bus.game_over   = (state_q == GAME_OVER);
  assign bus.enemy_speed = speed_q;
  assign bus.score_tens  = tens_q;
  assign bus.score_ones  = ones_q;
  assign bus.lives       = lives_q;
  assign bus.led         = led_q;
  assign bus.frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl: one task per scenario, expected
// values worked out by hand for the default parameters.
module tb_game_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  game_ctrl_if bus ();

  game_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A frame: Vsynq low for two cycles, high for two; tick effects are settled on return.
  task automatic do_frame();
    @(negedge clk) bus.Vsynq = 1'b0;
    @(negedge clk);
    @(negedge clk) bus.Vsynq = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_frames(input int n);
    for (int i = 0; i < n; i++) do_frame();
  endtask

  task automatic pulse_pass(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.enemy_pass = 1'b1;
      @(negedge clk) bus.enemy_pass = 1'b0;
    end
  endtask

  task automatic pulse_collision();
    @(negedge clk) bus.collision = 1'b1;
    @(negedge clk) bus.collision = 1'b0;
  endtask

  task automatic press_button();
    bus.button = 1'b1;
    do_frames(2);
    bus.button = 1'b0;
    do_frames(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk) bus.Vsynq = ~bus.Vsynq;
    bus.Vsynq = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.run !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_run: got %0b expected 0", bus.run); end
    n_checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h00) begin
      n_fail++; $display("[TB] FAIL reset_score: got %0h%0h expected 00", bus.score_tens, bus.score_ones);
    end
    n_checks++;
    if (bus.lives !== 3'd3) begin n_fail++; $display("[TB] FAIL reset_lives: got %0d expected 3", bus.lives); end
    n_checks++;
    if (bus.enemy_speed !== 4'd1) begin n_fail++; $display("[TB] FAIL reset_speed: got %0d expected 1", bus.enemy_speed); end
    n_checks++;
    if ({bus.game_over, bus.led, bus.frame_tick} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b expected 000", {bus.game_over, bus.led, bus.frame_tick});
    end
  endtask

  task automatic test_frame_tick();
    for (int f = 0; f < 2; f++) begin
      @(negedge clk) bus.Vsynq = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.frame_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL tick_early: got %0b expected 0", bus.frame_tick); end
      @(negedge clk);
      n_checks++;
      if (bus.frame_tick !== 1'b1) begin n_fail++; $display("[TB] FAIL tick_at_2clk: got %0b expected 1", bus.frame_tick); end
      bus.Vsynq = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.frame_tick !== 1'b0) begin n_fail++; $display("[TB] FAIL tick_one_cycle: got %0b expected 0", bus.frame_tick); end
      @(negedge clk);
    end
  endtask

  task automatic test_button();
    do_frames(2);
    n_checks++;
    if (bus.run !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_no_press: got run %0b expected 0", bus.run); end
    bus.button = 1'b1;
    do_frames(2);
    n_checks++;
    if (bus.run !== 1'b1) begin n_fail++; $display("[TB] FAIL press_to_play: got run %0b expected 1", bus.run); end
    do_frames(10);
    n_checks++;
    if ({bus.run, bus.game_over, bus.lives} !== {1'b1, 1'b0, 3'd3}) begin
      n_fail++; $display("[TB] FAIL held_button: got run %0b go %0b lives %0d expected 1 0 3", bus.run, bus.game_over, bus.lives);
    end
    bus.button = 1'b0;
    do_frames(2);
  endtask

  task automatic test_scoring();
    pulse_pass(4);
    n_checks++;
    if (bus.enemy_speed !== 4'd1) begin n_fail++; $display("[TB] FAIL speed_after_4: got %0d expected 1", bus.enemy_speed); end
    pulse_pass(1);
    n_checks++;
    if (bus.enemy_speed !== 4'd2) begin n_fail++; $display("[TB] FAIL speed_after_5: got %0d expected 2", bus.enemy_speed); end
    pulse_pass(5);
    n_checks++;
    if (bus.enemy_speed !== 4'd3) begin n_fail++; $display("[TB] FAIL speed_after_10: got %0d expected 3", bus.enemy_speed); end
    pulse_pass(2);
    n_checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h12) begin
      n_fail++; $display("[TB] FAIL score_12: got %0h%0h expected 12", bus.score_tens, bus.score_ones);
    end
  endtask

  task automatic test_hit();
    pulse_collision();
    n_checks++;
    if ({bus.lives, bus.run, bus.led} !== {3'd2, 1'b0, 1'b1}) begin
      n_fail++; $display("[TB] FAIL hit_entry: got lives %0d run %0b led %0b expected 2 0 1", bus.lives, bus.run, bus.led);
    end
    pulse_collision();
    n_checks++;
    if (bus.lives !== 3'd2) begin n_fail++; $display("[TB] FAIL hit_second_collision: got %0d expected 2", bus.lives); end
    do_frames(7);
    n_checks++;
    if (bus.led !== 1'b1) begin n_fail++; $display("[TB] FAIL led_7: got %0b expected 1", bus.led); end
    do_frames(1);
    n_checks++;
    if (bus.led !== 1'b0) begin n_fail++; $display("[TB] FAIL led_8: got %0b expected 0", bus.led); end
    do_frames(8);
    n_checks++;
    if (bus.led !== 1'b1) begin n_fail++; $display("[TB] FAIL led_16: got %0b expected 1", bus.led); end
    do_frames(43);
    n_checks++;
    if (bus.run !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_59: got run %0b expected 0", bus.run); end
    do_frames(1);
    n_checks++;
    if ({bus.run, bus.led} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL hit_60: got run %0b led %0b expected 1 0", bus.run, bus.led);
    end
  endtask

  task automatic test_game_over();
    pulse_collision();
    do_frames(60);
    n_checks++;
    if ({bus.lives, bus.run} !== {3'd1, 1'b1}) begin
      n_fail++; $display("[TB] FAIL second_hit: got lives %0d run %0b expected 1 1", bus.lives, bus.run);
    end
    pulse_collision();
    do_frames(60);
    n_checks++;
    if ({bus.game_over, bus.run, bus.lives} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++; $display("[TB] FAIL game_over: got go %0b run %0b lives %0d expected 1 0 0", bus.game_over, bus.run, bus.lives);
    end
    n_checks++;
    if ({bus.score_tens, bus.score_ones, bus.enemy_speed} !== 12'h123) begin
      n_fail++; $display("[TB] FAIL go_held: got %0h%0h spd %0d expected 12 spd 3", bus.score_tens, bus.score_ones, bus.enemy_speed);
    end
    press_button();
    n_checks++;
    if ({bus.game_over, bus.run, bus.score_tens, bus.score_ones, bus.lives, bus.enemy_speed} !== {2'b00, 8'h00, 3'd3, 4'd1}) begin
      n_fail++; $display("[TB] FAIL restart_idle: got go %0b run %0b score %0h%0h lives %0d spd %0d expected 0 0 00 3 1",
                         bus.game_over, bus.run, bus.score_tens, bus.score_ones, bus.lives, bus.enemy_speed);
    end
    press_button();
    n_checks++;
    if (bus.run !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_play: got run %0b expected 1", bus.run); end
  endtask

  task automatic test_collision_priority();
    pulse_pass(7);
    @(negedge clk) begin bus.collision = 1'b1; bus.enemy_pass = 1'b1; end
    @(negedge clk) begin bus.collision = 1'b0; bus.enemy_pass = 1'b0; end
    n_checks++;
    if ({bus.score_tens, bus.score_ones, bus.lives, bus.run} !== {8'h07, 3'd2, 1'b0}) begin
      n_fail++; $display("[TB] FAIL both_same_cycle: got %0h%0h lives %0d run %0b expected 07 2 0",
                         bus.score_tens, bus.score_ones, bus.lives, bus.run);
    end
    do_frames(60);
    n_checks++;
    if (bus.run !== 1'b1) begin n_fail++; $display("[TB] FAIL priority_resume: got run %0b expected 1", bus.run); end
  endtask

  task automatic test_reset_mid_hit();
    pulse_pass(35);
    n_checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h42) begin
      n_fail++; $display("[TB] FAIL score_42: got %0h%0h expected 42", bus.score_tens, bus.score_ones);
    end
    pulse_collision();
    do_frames(3);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    n_checks++;
    if ({bus.run, bus.game_over, bus.score_tens, bus.score_ones, bus.lives, bus.led, bus.enemy_speed} !==
        {2'b00, 8'h00, 3'd3, 1'b0, 4'd1}) begin
      n_fail++; $display("[TB] FAIL reset_mid_hit: got run %0b go %0b score %0h%0h lives %0d led %0b spd %0d expected 0 0 00 3 0 1",
                         bus.run, bus.game_over, bus.score_tens, bus.score_ones, bus.lives, bus.led, bus.enemy_speed);
    end
    n_checks++;
    if (dut.frame_cnt_q !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", dut.frame_cnt_q); end
  endtask

  task automatic test_saturation();
    press_button();
    pulse_pass(35);
    n_checks++;
    if ({bus.score_tens, bus.score_ones, bus.enemy_speed} !== 12'h358) begin
      n_fail++; $display("[TB] FAIL speed_cap: got %0h%0h spd %0d expected 35 spd 8", bus.score_tens, bus.score_ones, bus.enemy_speed);
    end
    pulse_pass(64);
    n_checks++;
    if ({bus.score_tens, bus.score_ones} !== 8'h99) begin
      n_fail++; $display("[TB] FAIL score_99: got %0h%0h expected 99", bus.score_tens, bus.score_ones);
    end
    pulse_pass(6);
    n_checks++;
    if ({bus.score_tens, bus.score_ones, bus.enemy_speed} !== 12'h998) begin
      n_fail++; $display("[TB] FAIL score_sat: got %0h%0h spd %0d expected 99 spd 8", bus.score_tens, bus.score_ones, bus.enemy_speed);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.Vsynq      = 1'b1;
    bus.button     = 1'b0;
    bus.collision  = 1'b0;
    bus.enemy_pass = 1'b0;
    test_reset();
    test_frame_tick();
    test_button();
    test_scoring();
    test_hit();
    test_game_over();
    test_collision_priority();
    test_reset_mid_hit();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer for the VGA runner game. Owns game state, lives, BCD score and enemy speed.
- Gates player/enemy motion through `run`, and drives the score digits that feed the seven-segment task logic in the top module.
- All game decisions are taken on a per-frame tick derived from Vsynq. The block sits beside render/enemy/player and replaces the free-running score counter.

Parameters:
LIVES, 3, lives at game start (1..7)
HIT_FRAMES, 60, frames frozen after a hit (1..255)
SPEED_STEP, 5, points per enemy-speed increment (1..99)
BASE_SPEED, 1, enemy speed at game start (0..15)
MAX_SPEED, 8, enemy speed ceiling (BASE_SPEED..15)

Ports:
clk  input  1  system clock (same clock as vga/render)
reset  input  1  synchronous, active-high reset
Vsynq  input  1  vertical sync from vga, active-low pulse
button  input  1  player button, active-high, asynchronous to clk
collision  input  1  level from render, player/enemy overlap
enemy_pass  input  1  one-cycle pulse from enemy when it leaves the screen unhit
run  output  1  1 = player/enemy may move
enemy_speed  output  4  enemy pixels per frame
score_tens  output  4  BCD tens digit
score_ones  output  4  BCD ones digit
lives  output  3  remaining lives
game_over  output  1  high in GAME_OVER state
led  output  1  hit indicator, toggles every 8 frames during HIT, else 0
frame_tick  output  1  one-cycle pulse per frame

Behaviour:
- Reset (synchronous, active-high): state=IDLE, run=0, enemy_speed=BASE_SPEED, score=00, lives=LIVES, game_over=0, led=0, frame_tick=0. Synchronizers, edge registers and the frame counter are cleared.
- Frame tick:
  - Vsynq is registered once; frame_tick=1 for one cycle when prev=1 and cur=0.
  - Latency is 2 clk from the Vsynq falling edge.
- Button:
  - button passes through a 2-flop synchronizer.
  - On each frame_tick the synced value is sampled into btn_frame.
  - press = frame_tick & sampled=1 & previous btn_frame=0. One press per frame at most; a held button never re-triggers.
- States:
  - IDLE: run=0. press -> PLAYING. On entry from GAME_OVER: score=00, lives=LIVES, speed=BASE_SPEED.
  - PLAYING: run=1.
    - Any cycle with collision=1 -> HIT; lives decrements in the same cycle.
    - enemy_pass increments the score (BCD).
    - If collision and enemy_pass occur in the same cycle, the collision wins and the score is not incremented.
  - HIT: run=0. collision and enemy_pass are ignored. A frame counter counts frame_ticks.
    - After HIT_FRAMES ticks: if lives=0 -> GAME_OVER, else -> PLAYING.
    - The frame counter clears on entry.
  - GAME_OVER: game_over=1, run=0. Score and speed are held for display. press -> IDLE.
- Score:
  - Two BCD digits. Ones wraps 9->0 with carry into tens.
  - Saturates at 99; further passes are ignored. No binary divide is used.
- Speed:
  - A points-since-step counter increments with each scored point.
  - When it reaches SPEED_STEP it clears, and enemy_speed increments, saturating at MAX_SPEED.
  - The speed update takes effect on the cycle after the scoring pulse.
- lives never underflows; decrementing is blocked at 0.
- led: 0 outside HIT. In HIT it toggles on every 8th frame_tick, starting at 1 on entry.
- Reset mid-game (any state) returns to IDLE with all reset values on the next edge.
- Outputs are registered, no combinational paths from inputs to outputs, except that run and game_over decode the state register.

Test Plan:
1. Reset held 3 cycles, Vsynq toggling -> state IDLE, score 00, lives 3, speed 1, run 0. frame_tick pulses exactly 2 clk after each Vsynq fall.
2. Button pressed across 2 frames then held 10 frames -> single IDLE->PLAYING transition, run=1. No further state change while held.
3. In PLAYING, 12 enemy_pass pulses -> score_tens=1, score_ones=2. enemy_speed=2 after the 5th pass, 3 after the 10th. With 105 passes (SPEED_STEP=5, MAX=8) -> score holds 99, speed holds 8.
4. collision for 1 cycle -> lives 3->2, run=0, led toggles every 8 frames. Second collision during HIT is ignored (lives stays 2). After 60 frame_ticks -> PLAYING, run=1.
5. collision and enemy_pass in the same cycle at score 07 -> HIT, score stays 07, lives decremented. Three hits total -> GAME_OVER after the third HIT period, game_over=1, score held. A new press -> IDLE, and a second press -> PLAYING with score 00, lives 3, speed 1.
6. reset asserted for 1 cycle mid-HIT with score 42 -> next cycle IDLE, score 00, lives 3, led 0, frame counter 0.
